// File: rtl/ready_cut_fifo.sv
// ready_cut_fifo: elastic FIFO that breaks the combinational ready path.
// ins_ready comes from registered occupancy only. When the FIFO is empty
// and the consumer is ready, data passes straight through with zero latency.
module ready_cut_fifo #(
  parameter int DATA_TYPE = 32,
  parameter int NUM_SLOTS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] ins,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  output logic [DATA_TYPE-1:0] outs,
  output logic                 outs_valid,
  input  logic                 outs_ready
);

  localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

  logic [CNT_W-1:0]     count;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [DATA_TYPE-1:0] mem [NUM_SLOTS];

  logic empty;
  logic full;
  logic enq;
  logic deq;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // Handshake outputs are gated while reset is held so nothing leaks out
  // of a FIFO that is being cleared; outs already falls back to ins there
  // because the FIFO is empty during reset.
  assign ins_ready  = ~full & rst;
  assign outs_valid = (~empty | ins_valid) & rst;
  assign outs       = empty ? ins : mem[rd_ptr];

  // An empty FIFO with a ready consumer forwards the token without storing it.
  assign deq = outs_ready & ~empty & rst;
  assign enq = ins_valid & ins_ready & ~(empty & outs_ready);

  // Occupancy counter: simultaneous enq and deq leave it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Read and write pointers, each wrapping at NUM_SLOTS-1 so any depth works.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage array, cleared on reset so no stale data can ever appear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        mem[i] <= '0;
      end
    end else if (enq) begin
      mem[wr_ptr] <= ins;
    end
  end

endmodule

// File: tb/tb_ready_cut_fifo.sv
// Bench for ready_cut_fifo: a depth-4 instance driven by directed vectors
// and a depth-3 instance driven by a random valid/ready stream. A queue
// model of each FIFO is compared against the outputs every cycle.
module tb_ready_cut_fifo;

  logic clk = 1'b0;

  logic        rst_a = 1'b0;
  logic [31:0] a_ins = 32'h0;
  logic        a_iv = 1'b0;
  logic        a_or = 1'b0;
  logic        a_ins_ready;
  logic [31:0] a_outs;
  logic        a_outs_valid;

  logic        rst_b = 1'b0;
  logic [31:0] b_ins = 32'h0;
  logic        b_iv = 1'b0;
  logic        b_or = 1'b0;
  logic        b_ins_ready;
  logic [31:0] b_outs;
  logic        b_outs_valid;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  ready_cut_fifo #(.DATA_TYPE(32), .NUM_SLOTS(4)) dut_a (
    .clk(clk), .rst(rst_a), .ins(a_ins), .ins_valid(a_iv), .ins_ready(a_ins_ready),
    .outs(a_outs), .outs_valid(a_outs_valid), .outs_ready(a_or)
  );

  ready_cut_fifo #(.DATA_TYPE(32), .NUM_SLOTS(3)) dut_b (
    .clk(clk), .rst(rst_b), .ins(b_ins), .ins_valid(b_iv), .ins_ready(b_ins_ready),
    .outs(b_outs), .outs_valid(b_outs_valid), .outs_ready(b_or)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic check_word(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(string name, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs follow directly from occupancy: ready while not full,
  // valid when something is stored or offered, head of queue else bypass.
  task automatic check_model(string tag, int size, int cap, logic rstv, logic iv,
                             logic [31:0] ins, logic [31:0] head,
                             logic rdy, logic vld, logic [31:0] o);
    check_bit({tag, "_ins_ready"}, rdy, rstv && (size < cap));
    check_bit({tag, "_outs_valid"}, vld, rstv && ((size > 0) || iv));
    check_word({tag, "_outs"}, o, (size > 0) ? head : ins);
  endtask

  // Queue model for the depth-4 FIFO: pop on consumer take of stored data,
  // push accepted tokens unless they were passed straight through.
  always @(posedge clk) begin : model_a
    bit was_empty;
    bit acc;
    if (rst_a) begin
      was_empty = (qa.size() == 0);
      acc = a_iv && (qa.size() < 4);
      if (a_or && !was_empty) void'(qa.pop_front());
      if (acc && !(was_empty && a_or)) qa.push_back(a_ins);
    end
  end

  always @(negedge rst_a) qa.delete();

  // Queue model for the depth-3 FIFO, same rules.
  always @(posedge clk) begin : model_b
    bit was_empty;
    bit acc;
    if (rst_b) begin
      was_empty = (qb.size() == 0);
      acc = b_iv && (qb.size() < 3);
      if (b_or && !was_empty) void'(qb.pop_front());
      if (acc && !(was_empty && b_or)) qb.push_back(b_ins);
    end
  end

  always @(negedge rst_b) qb.delete();

  // Compare both DUTs against their models on every falling edge.
  always @(negedge clk) begin
    check_model("a", qa.size(), 4, rst_a, a_iv, a_ins, (qa.size() > 0) ? qa[0] : 32'h0,
                a_ins_ready, a_outs_valid, a_outs);
    check_model("b", qb.size(), 3, rst_b, b_iv, b_ins, (qb.size() > 0) ? qb[0] : 32'h0,
                b_ins_ready, b_outs_valid, b_outs);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(logic [31:0] ins, logic iv, logic ordy);
    a_ins = ins;
    a_iv  = iv;
    a_or  = ordy;
  endtask

  task automatic check_output(string name, logic rdy, logic vld, logic [31:0] o);
    #2;
    check_bit({name, "_ready"}, a_ins_ready, rdy);
    check_bit({name, "_valid"}, a_outs_valid, vld);
    check_word({name, "_outs"}, a_outs, o);
  endtask

  // Directed scenarios on the depth-4 instance, then the random run on depth 3.
  initial begin : stim
    logic [31:0] exp_drain [5];
    int next_in;
    int recv;
    int cycles;
    bit acc;

    exp_drain[0] = 32'd1; exp_drain[1] = 32'd2; exp_drain[2] = 32'd3;
    exp_drain[3] = 32'd4; exp_drain[4] = 32'd5;

    // Reset held with a valid producer: handshakes gated, outs mirrors ins.
    apply_stimulus(32'h77, 1'b1, 1'b0);
    step();
    step();
    check_output("reset", 1'b0, 1'b0, 32'h77);

    // Release and bypass in the same cycle.
    step();
    rst_a = 1'b1;
    apply_stimulus(32'hA5, 1'b1, 1'b1);
    check_output("bypass", 1'b1, 1'b1, 32'hA5);
    step();
    apply_stimulus(32'h0, 1'b0, 1'b1);
    check_output("bypass_nostore", 1'b1, 1'b0, 32'h0);

    // Fill to full with the consumer stalled.
    for (int i = 1; i <= 4; i++) begin
      step();
      apply_stimulus(32'(i), 1'b1, 1'b0);
      check_output("fill", 1'b1, 1'b1, 32'd1);
    end
    step();
    apply_stimulus(32'd5, 1'b1, 1'b0);
    check_output("full", 1'b0, 1'b1, 32'd1);

    // Drain with the fifth token pending; ready returns one cycle after first deq.
    for (int k = 0; k < 5; k++) begin
      step();
      apply_stimulus(32'd5, (k < 2), 1'b1);
      check_output("drain", (k != 0), 1'b1, exp_drain[k]);
    end
    step();
    apply_stimulus(32'h0, 1'b0, 1'b1);
    check_output("drained", 1'b1, 1'b0, 32'h0);

    // Two stored tokens, then ten cycles of simultaneous enq and deq.
    step();
    apply_stimulus(32'h10, 1'b1, 1'b0);
    step();
    apply_stimulus(32'h11, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      apply_stimulus(32'h12 + 32'(k), 1'b1, 1'b1);
      check_output("steady", 1'b1, 1'b1, 32'h10 + 32'(k));
    end
    step();
    apply_stimulus(32'h0, 1'b0, 1'b1);
    check_output("steady_tail0", 1'b1, 1'b1, 32'h1A);
    step();
    check_output("steady_tail1", 1'b1, 1'b1, 32'h1B);
    step();
    check_output("steady_empty", 1'b1, 1'b0, 32'h0);

    // Three stored tokens, then asynchronous reset between clock edges.
    for (int k = 0; k < 3; k++) begin
      step();
      apply_stimulus(32'h30 + 32'(k), 1'b1, 1'b0);
    end
    step();
    apply_stimulus(32'h0, 1'b0, 1'b0);
    #2;
    check_bit("pre_reset_valid", a_outs_valid, 1'b1);
    rst_a = 1'b0;
    #1;
    check_bit("async_reset_valid", a_outs_valid, 1'b0);
    check_bit("async_reset_ready", a_ins_ready, 1'b0);
    step();
    rst_a = 1'b1;
    apply_stimulus(32'hBB, 1'b1, 1'b1);
    check_output("post_reset_bypass", 1'b1, 1'b1, 32'hBB);
    step();
    apply_stimulus(32'h0, 1'b0, 1'b1);
    check_output("post_reset_empty", 1'b1, 1'b0, 32'h0);

    // Random valid/ready on the depth-3 FIFO with an incrementing stream.
    step();
    rst_b = 1'b1;
    next_in = 0;
    recv = 0;
    cycles = 0;
    acc = 1'b0;
    while (recv < 1000 && cycles < 20000) begin
      step();
      cycles++;
      if (acc) next_in++;
      b_ins = 32'(next_in);
      b_iv  = (next_in < 1000) && ($urandom_range(1) == 1);
      b_or  = ($urandom_range(1) == 1);
      #3;
      acc = b_iv && b_ins_ready;
      if (b_outs_valid && b_or) begin
        check_word("b_order", b_outs, 32'(recv));
        recv++;
      end
      if (cycles % 50 == 0) check_bit("b_occupancy", (next_in - recv) <= 3, 1'b1);
    end
    check_bit("b_finished", recv == 1000, 1'b1);
    check_word("b_accepted", 32'(next_in + (acc ? 1 : 0)), 32'd1000);

    step();
    b_iv = 1'b0;
    b_or = 1'b0;
    a_iv = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ready_cut_fifo.md
# ready_cut_fifo

Elastic FIFO that cuts the backward (ready) combinational path, the counterpart of our valid-cutting opaque half buffer. Data bypasses combinationally when the FIFO is empty and the consumer is ready (zero latency). `ins_ready` depends only on registered occupancy. Placed between dataflow units wherever a long `ready` chain must be broken while keeping zero-latency forwarding.

## Interface
- `DATA_TYPE`, 32: data width in bits, ≥1.
- `NUM_SLOTS`, 4: storage depth, ≥1; any integer (not restricted to powers of two).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ins`  in  DATA_TYPE  input data.
- `ins_valid`  in  1  producer valid.
- `ins_ready`  out  1  FIFO can accept; function of registered state only.
- `outs`  out  DATA_TYPE  output data.
- `outs_valid`  out  1  output valid.
- `outs_ready`  in  1  consumer ready.

## Operation
- State: `count` (0..NUM_SLOTS), `rd_ptr` and `wr_ptr` (0..NUM_SLOTS-1), and storage `mem[NUM_SLOTS]`.
- `empty` = (count == 0); `full` = (count == NUM_SLOTS).
- `ins_ready` = ~full. No combinational path from `outs_ready` or `ins_valid`.
- `outs_valid` = ~empty | ins_valid.
- `outs` = empty ? `ins` : mem[rd_ptr] (bypass when empty).
- Transfer rules:
  - `deq` = outs_ready & ~empty.
  - `enq` = ins_valid & ins_ready & ~(empty & outs_ready). An empty FIFO with a ready consumer passes the token through without storing it.
- On `enq`: mem[wr_ptr] ← ins; wr_ptr advances, wrapping from NUM_SLOTS-1 to 0.
- On `deq`: rd_ptr advances with the same wrap rule.
- `count` ← count + enq − deq. Simultaneous enq and deq leaves `count` unchanged.
- Order is strictly FIFO. Tokens are never dropped or duplicated.
- Full with `outs_ready`=1: deq occurs, but `ins_ready` stays 0 that cycle and rises the next cycle.
- Once `outs_valid` is raised by stored data, it must hold with stable `outs` until `outs_ready`. In the bypass case, stability is the producer's obligation.

## Timing
- Reset (`rst`=0, asynchronous): count=0, rd_ptr=wr_ptr=0, mem cleared to 0.
  - While `rst`=0: `ins_ready`=0 and `outs_valid`=0 (gated), `outs` = `ins`.
  - After release: `ins_ready`=1; `outs_valid` follows `ins_valid`.
- Latency:
  - Empty FIFO with ready consumer: 0 cycles, same-cycle handshake on both sides.
  - Otherwise: a token accepted at edge k is presented after all older tokens, at the earliest the cycle after k.
- Throughput: 1 token/cycle sustained in steady state, both bypass and non-empty.
- Backpressure: accepts NUM_SLOTS tokens while `outs_ready`=0. The (NUM_SLOTS+1)-th sees `ins_ready`=0.
- Reset mid-operation discards all stored tokens immediately. There is no partial handshake.
- NUM_SLOTS=1: behaves as a transparent half buffer with a registered ready.

## Test plan
- **Reset and bypass.** Hold rst=0 with ins_valid=1 → ins_ready=0, outs_valid=0. Release rst, drive ins=0xA5, ins_valid=1, outs_ready=1 → same cycle outs=0xA5, outs_valid=1, ins_ready=1; count stays 0.
- **Fill to full.** NUM_SLOTS=4, outs_ready=0, push 1,2,3,4 on consecutive cycles → ins_ready=0 after the 4th edge. A 5th token is held by the producer. outs=1 and outs_valid=1 throughout.
- **Full then drain.** From full, outs_ready=1 with a 5th token pending → outs sequence 1,2,3,4,5. ins_ready rises exactly one cycle after the first deq. No loss.
- **Wrap-around.** NUM_SLOTS=3, random valid/ready (50%) over 1000 tokens of an incrementing pattern → output is the exact increasing sequence. Occupancy never exceeds 3.
- **Simultaneous enq/deq.** count=2, ins_valid=1, outs_ready=1 for 10 cycles → count stays 2 and 10 tokens exit in order.
- **Async reset mid-stream.** count=3, assert rst between clock edges → outs_valid=0 immediately. After release, the first new token bypasses with no stale data.
